// File: rtl/edge_detector_filt.sv
// Multi-channel edge detector: per-channel synchroniser, programmable glitch filter,
// enabled edge pulses, sticky event flags and a registered interrupt summary.
module edge_detector_filt #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 4,
  parameter bit          RESET_LEVEL = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  signal,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [WIDTH-1:0]  pos_en,
  input  logic [WIDTH-1:0]  neg_en,
  input  logic [WIDTH-1:0]  clr,
  output logic [WIDTH-1:0]  filtered,
  output logic [WIDTH-1:0]  pos_edge,
  output logic [WIDTH-1:0]  neg_edge,
  output logic [WIDTH-1:0]  event_flag,
  output logic              irq
);

  localparam logic [WIDTH-1:0] ResetVec = {WIDTH{RESET_LEVEL}};

  logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]  sync_out;
  logic [FILT_W-1:0] cnt_q  [WIDTH];
  logic [FILT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0]  filt_q, filt_d;
  logic [WIDTH-1:0]  pos_q, pos_d;
  logic [WIDTH-1:0]  neg_q, neg_d;
  logic [WIDTH-1:0]  flag_q, flag_d;
  logic              irq_q, irq_d;
  logic              filt_on;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= ResetVec;
    end else begin
      sync_q[0] <= signal;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign filt_on  = filt_len > FILT_W'(1);

  // The >= threshold lets a shortened filt_len release a channel that has already counted past it.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (!filt_on) begin
        filt_d[i] = sync_out[i];
      end else if (sync_out[i] != filt_q[i]) begin
        if (cnt_q[i] >= filt_len - FILT_W'(1)) begin
          filt_d[i] = sync_out[i];
        end else begin
          cnt_d[i] = cnt_q[i] + FILT_W'(1);
        end
      end
    end
  end

  always_comb begin
    pos_d  = pos_en & filt_d & ~filt_q;
    neg_d  = neg_en & ~filt_d & filt_q;
    // A new edge takes priority over a clear on the same clock.
    flag_d = pos_d | neg_d | (flag_q & ~clr);
    irq_d  = |flag_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      filt_q <= ResetVec;
      pos_q  <= '0;
      neg_q  <= '0;
      flag_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      filt_q <= filt_d;
      pos_q  <= pos_d;
      neg_q  <= neg_d;
      flag_q <= flag_d;
      irq_q  <= irq_d;
    end
  end

  assign filtered   = filt_q;
  assign pos_edge   = pos_q;
  assign neg_edge   = neg_q;
  assign event_flag = flag_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_edge_detector_filt.sv
// Randomised scoreboard bench for edge_detector_filt against a cycle-level reference model.
module tb_edge_detector_filt;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned FILT_W = 4;

  typedef struct packed {
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] pos;
    logic [WIDTH-1:0] neg;
    logic [WIDTH-1:0] flag;
    logic             irq;
  } obs_t;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [WIDTH-1:0]  signal = '0;
  logic [FILT_W-1:0] filt_len = '0;
  logic [WIDTH-1:0]  pos_en = '0;
  logic [WIDTH-1:0]  neg_en = '0;
  logic [WIDTH-1:0]  clr = '0;
  logic [WIDTH-1:0]  filtered, pos_edge, neg_edge, event_flag;
  logic              irq;

  edge_detector_filt #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .FILT_W(FILT_W), .RESET_LEVEL(1'b0)
  ) dut (
    .CLK(CLK), .RST(RST), .signal(signal), .filt_len(filt_len), .pos_en(pos_en),
    .neg_en(neg_en), .clr(clr), .filtered(filtered), .pos_edge(pos_edge),
    .neg_edge(neg_edge), .event_flag(event_flag), .irq(irq)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  obs_t exp_q[$];

  // Reference model: raw samples delayed through a queue, then a per-channel run length of
  // cycles on which the synchronised level disagrees with the filtered level.
  logic [WIDTH-1:0] hist[$];
  logic [WIDTH-1:0] m_filt, m_flag;
  int               run[WIDTH];

  function automatic obs_t cur_obs();
    obs_t o;
    o.filt = filtered; o.pos = pos_edge; o.neg = neg_edge; o.flag = event_flag; o.irq = irq;
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got filt=%h pos=%h neg=%h flag=%h irq=%b, exp filt=%h pos=%h neg=%h flag=%h irq=%b",
               name, got.filt, got.pos, got.neg, got.flag, got.irq,
               exp.filt, exp.pos, exp.neg, exp.flag, exp.irq);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < SYNC; k++) hist.push_back('0);
    m_filt = '0;
    m_flag = '0;
    for (int b = 0; b < WIDTH; b++) run[b] = 0;
  endtask

  // Drive one cycle of inputs (called just after a falling edge) and queue the expectation.
  task automatic step(input logic [WIDTH-1:0] sg, input int fl, input logic [WIDTH-1:0] pe,
                      input logic [WIDTH-1:0] ne, input logic [WIDTH-1:0] cl);
    logic [WIDTH-1:0] s, nf;
    int   thr;
    obs_t e;
    signal = sg; filt_len = FILT_W'(fl); pos_en = pe; neg_en = ne; clr = cl;
    s = hist.pop_front();
    hist.push_back(sg);
    thr = (fl <= 1) ? 1 : fl;
    nf = m_filt;
    for (int b = 0; b < WIDTH; b++) begin
      if (s[b] != m_filt[b]) begin
        run[b]++;
        if (run[b] >= thr) begin
          nf[b] = s[b];
          run[b] = 0;
        end
      end else begin
        run[b] = 0;
      end
    end
    e.pos  = pe & nf & ~m_filt;
    e.neg  = ne & ~nf & m_filt;
    m_flag = e.pos | e.neg | (m_flag & ~cl);
    m_filt = nf;
    e.filt = nf;
    e.flag = m_flag;
    e.irq  = |m_flag;
    exp_q.push_back(e);
  endtask

  task automatic reset_check(input string name);
    obs_t z;
    z = '0;
    RST = 1'b1;
    #2;
    check(name, cur_obs(), z);
    @(posedge CLK);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    model_reset();
  endtask

  always @(posedge CLK) begin
    #1;
    if (exp_q.size() > 0) check("cycle", cur_obs(), exp_q.pop_front());
  end

  initial begin
    logic [WIDTH-1:0] sg, pe, ne, flip;
    int fl, dens;
    sg = '0; pe = '1; ne = '1; fl = 0; dens = 4;
    #3;
    reset_check("reset_state");

    // Single rising channel, no filter: pulse appears after the third edge.
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      step(8'h01, 0, 8'hFF, 8'hFF, 8'h00);
    end
    // Short and long pulses on ch0 through a length-4 filter.
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      sg = (c >= 2 && c < 5) || (c >= 15 && c < 19) ? 8'h00 : 8'h01;
      step(sg, 4, 8'hFF, 8'hFF, 8'h00);
    end

    for (int c = 0; c < 2400; c++) begin
      if (c == 900 || c == 1700) begin
        @(negedge CLK);
        reset_check(c == 900 ? "mid_reset_a" : "mid_reset_b");
      end
      if (c % 37 == 0) begin
        fl = $urandom_range(0, 8);
        dens = $urandom_range(1, 9);
      end
      if (c % 11 == 0) begin
        pe = WIDTH'($urandom);
        ne = WIDTH'($urandom);
      end
      flip = '0;
      for (int b = 0; b < WIDTH; b++)
        if ($urandom_range(0, dens) == 0) flip[b] = 1'b1;
      sg = sg ^ flip;
      @(negedge CLK);
      step(sg, fl, pe, ne, WIDTH'($urandom & $urandom & $urandom));
    end

    @(posedge CLK);
    @(posedge CLK);
    #3;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending expectations, exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
